// File: rtl/mash_nstage.sv
// mash_nstage: MASH 1-1-..-1 sigma-delta modulator with run-time order select and LFSR LSB dither
module mash_nstage #(
    parameter int          WIDTH     = 24,
    parameter int          MAX_ORDER = 4,
    parameter logic [14:0] LFSR_SEED = 15'h0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic                    load_valid_i,
    output logic                    load_ready_o,
    input  logic [WIDTH-1:0]        x_i,
    input  logic [2:0]              order_i,
    input  logic                    dither_en_i,
    output logic signed [4:0]       y_o,
    output logic [WIDTH-1:0]        e_o,
    output logic                    busy_o
);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] x_reg;
    logic [2:0]       order_reg, order_cl;
    logic             dither_reg, accept, step;
    logic [14:0]      lfsr;
    logic [WIDTH-1:0] acc [1:MAX_ORDER];
    logic [WIDTH:0]   in_w [1:MAX_ORDER+1];
    logic [WIDTH:0]   sum [1:MAX_ORDER];
    logic [4:0]       d [1:MAX_ORDER+1];
    logic [4:0]       dz [2:MAX_ORDER+1];
    logic [WIDTH-1:0] e_nx;
    int               m;

    always_comb begin
        m = int'(order_reg);
        order_cl = (order_i == 3'd0) ? 3'd1 : (order_i > 3'(MAX_ORDER)) ? 3'(MAX_ORDER) : order_i;
        accept = load_valid_i && load_ready_o;
        state_nx = !en_i ? IDLE : (state == RUN && accept && order_cl != order_reg) ? FLUSH : RUN;
        // accumulators only advance on RUN->RUN edges; entry, exit and flush edges clear them
        step = (state == RUN) && (state_nx == RUN);
        in_w[1] = {1'b0, x_reg} + {{WIDTH{1'b0}}, dither_reg & lfsr[0]};
        for (int k = 1; k <= MAX_ORDER; k++) begin
            sum[k] = (k <= m) ? {1'b0, acc[k]} + in_w[k] : '0;
            in_w[k+1] = {1'b0, sum[k][WIDTH-1:0]};
        end
        d[MAX_ORDER+1] = '0;
        for (int k = MAX_ORDER; k >= 1; k--)
            d[k] = {4'd0, sum[k][WIDTH]} + ((k < m) ? d[k+1] - dz[k+1] : 5'd0);
        e_nx = '0;
        for (int k = 1; k <= MAX_ORDER; k++)
            e_nx = (k == m) ? sum[k][WIDTH-1:0] : e_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            x_reg        <= '0;
            order_reg    <= 3'd1;
            dither_reg   <= 1'b0;
            lfsr         <= LFSR_SEED;
            busy_o       <= 1'b0;
            load_ready_o <= 1'b1;
            y_o          <= '0;
            e_o          <= '0;
            for (int k = 1; k <= MAX_ORDER; k++) acc[k] <= '0;
            for (int k = 2; k <= MAX_ORDER + 1; k++) dz[k] <= '0;
        end else begin
            state        <= state_nx;
            busy_o       <= state_nx != IDLE;
            load_ready_o <= state_nx != FLUSH;
            if (accept) begin
                x_reg      <= x_i;
                order_reg  <= order_cl;
                dither_reg <= dither_en_i;
            end
            if (state == RUN) lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            y_o <= step ? d[1] : '0;
            e_o <= step ? e_nx : '0;
            for (int k = 1; k <= MAX_ORDER; k++) acc[k] <= step ? sum[k][WIDTH-1:0] : '0;
            for (int k = 2; k <= MAX_ORDER + 1; k++) dz[k] <= step ? d[k] : '0;
        end
    end
endmodule

// File: tb/tb_mash_nstage.sv
// tb_mash_nstage: directed self-checking bench for mash_nstage (WIDTH=8, MAX_ORDER=4)
module tb_mash_nstage;
    logic              clk = 1'b0;
    logic              rst, en_i, load_valid_i, load_ready_o, dither_en_i, busy_o;
    logic [7:0]        x_i, e_o;
    logic [2:0]        order_i;
    logic signed [4:0] y_o;
    int                checks = 0, errors = 0;
    int                bad, acc_sum, lo, hi;

    mash_nstage #(.WIDTH(8), .MAX_ORDER(4), .LFSR_SEED(15'h0001)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .load_valid_i(load_valid_i),
        .load_ready_o(load_ready_o), .x_i(x_i), .order_i(order_i),
        .dither_en_i(dither_en_i), .y_o(y_o), .e_o(e_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int y, input int e, input int busy, input int rdy);
        chk({tag, "_y"}, int'(y_o), y);
        chk({tag, "_e"}, int'(e_o), e);
        chk({tag, "_busy"}, int'(busy_o), busy);
        chk({tag, "_ready"}, int'(load_ready_o), rdy);
    endtask

    task automatic load(input int x, input int ord, input logic dith);
        load_valid_i = 1'b1;
        x_i = 8'(x);
        order_i = 3'(ord);
        dither_en_i = dith;
    endtask

    initial begin
        rst = 1'b1; en_i = 1'b0; load_valid_i = 1'b0; x_i = '0; order_i = '0; dither_en_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_outs("reset", 0, 0, 0, 1);
        chk("reset_state", int'(dut.state), 0);
        chk("reset_lfsr", int'(dut.lfsr), 1);
        chk("reset_order", int'(dut.order_reg), 1);
        rst = 1'b0;

        // order clamping: 7 -> 4, 0 -> 1
        load(64, 7, 1'b0);
        @(negedge clk);
        chk("clamp_hi", int'(dut.order_reg), 4);
        load(64, 0, 1'b0);
        @(negedge clk);
        chk("clamp_lo", int'(dut.order_reg), 1);
        chk("load_x", int'(dut.x_reg), 64);
        load_valid_i = 1'b0;

        // order 1, x=64: carry every 4th cycle, residue ramps by 64
        en_i = 1'b1;
        @(negedge clk);
        chk_outs("o1_entry", 0, 0, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("o1_y%0d", k), int'(y_o), (k % 4 == 0) ? 1 : 0);
            chk($sformatf("o1_e%0d", k), int'(e_o), (64 * k) % 256);
        end

        // same-order load in RUN: no clear, new x used from the following cycle
        load(128, 1, 1'b0);
        @(negedge clk);
        load_valid_i = 1'b0;
        chk_outs("same_ord0", 0, 64, 1, 1);
        @(negedge clk);
        chk_outs("same_ord1", 0, 192, 1, 1);
        @(negedge clk);
        chk_outs("same_ord2", 1, 64, 1, 1);

        // x=0, order 4 for 1000 cycles
        en_i = 1'b0;
        @(negedge clk);
        load(0, 4, 1'b0);
        @(negedge clk);
        load_valid_i = 1'b0;
        en_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (y_o !== 5'sd0 || e_o !== 8'd0) bad++;
        end
        chk("x0_nonzero_cycles", bad, 0);
        chk("x0_busy", int'(busy_o), 1);

        // load coinciding with en_i falling: accepted, straight to IDLE
        en_i = 1'b0;
        load(128, 3, 1'b0);
        @(negedge clk);
        load_valid_i = 1'b0;
        chk("fall_state", int'(dut.state), 0);
        chk("fall_order", int'(dut.order_reg), 3);
        chk_outs("fall", 0, 0, 0, 1);

        // order 3, x=128, 2048 cycles
        en_i = 1'b1;
        @(negedge clk);
        bad = 0; acc_sum = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (y_o < -5'sd3 || y_o > 5'sd4) bad++;
            acc_sum += int'(y_o);
        end
        chk("o3_range", bad, 0);
        chk("o3_sum_ok", int'(acc_sum >= 1020 && acc_sum <= 1028), 1);

        // order 2 -> 4 change in RUN forces a one-cycle FLUSH
        en_i = 1'b0;
        load(100, 2, 1'b0);
        @(negedge clk);
        load_valid_i = 1'b0;
        en_i = 1'b1;
        repeat (20) @(negedge clk);
        load(100, 4, 1'b0);
        @(negedge clk);
        load_valid_i = 1'b0;
        chk_outs("flush", 0, 0, 1, 0);
        chk("flush_state", int'(dut.state), 2);
        chk("flush_order", int'(dut.order_reg), 4);
        @(negedge clk);
        chk_outs("flush_exit", 0, 0, 1, 1);
        @(negedge clk);
        chk_outs("restart1", 0, 100, 1, 1);
        @(negedge clk);
        chk_outs("restart2", 1, 244, 1, 1);

        // x=255, order 4, dither on, 4096 cycles
        en_i = 1'b0;
        load(255, 4, 1'b1);
        @(negedge clk);
        load_valid_i = 1'b0;
        en_i = 1'b1;
        @(negedge clk);
        bad = 0; acc_sum = 0; lo = 0; hi = 0;
        for (int k = 0; k < 4096; k++) begin
            @(negedge clk);
            if (y_o < -5'sd7 || y_o > 5'sd8) bad++;
            acc_sum += int'(y_o);
        end
        chk("o4d_range", bad, 0);
        chk("o4d_mean_ok", int'(acc_sum >= 4055 && acc_sum <= 4096), 1);

        // reset mid-RUN wins over en_i and a pending load
        rst = 1'b1;
        load(77, 2, 1'b1);
        @(negedge clk);
        chk_outs("midrst", 0, 0, 0, 1);
        chk("midrst_state", int'(dut.state), 0);
        chk("midrst_lfsr", int'(dut.lfsr), 1);
        chk("midrst_order", int'(dut.order_reg), 1);
        chk("midrst_x", int'(dut.x_reg), 0);
        chk("midrst_dither", int'(dut.dither_reg), 0);
        rst = 1'b0; load_valid_i = 1'b0; en_i = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mash_nstage.md
MASH_NSTAGE -- requirements
Module: mash_nstage

Interface
REQ-001 SHALL have parameter WIDTH, default 24: accumulator and input word width.
REQ-002 SHALL have parameter MAX_ORDER, default 4, legal 1..4: number of instantiated accumulator stages.
REQ-003 SHALL have parameter LFSR_SEED, default 15'h0001, nonzero: dither LFSR reset value.
REQ-004 SHALL have port clk input 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst input 1: reset, synchronous and active-high.
REQ-006 SHALL have port en_i input 1: modulator run enable.
REQ-007 SHALL have port load_valid_i input 1: new x/order/dither setting offered.
REQ-008 SHALL have port load_ready_o output 1: setting accepted when valid and ready are both high on a clock edge.
REQ-009 SHALL have port x_i input WIDTH: unsigned fractional input, value x/2^WIDTH.
REQ-010 SHALL have port order_i input 3: requested active order; 0 treated as 1, values above MAX_ORDER treated as MAX_ORDER.
REQ-011 SHALL have port dither_en_i input 1: enable LSB dither on stage 1.
REQ-012 SHALL have port y_o output 5: signed two's-complement divider-offset output.
REQ-013 SHALL have port e_o output WIDTH: residue of the last active stage.
REQ-014 SHALL have port busy_o output 1: high in RUN and FLUSH states.

Function
REQ-015 SHALL hold x_reg, order_reg, dither_reg, loaded only on a valid&ready edge; load_ready_o SHALL be high in IDLE and RUN, low in FLUSH.
REQ-016 SHALL implement FSM IDLE/RUN/FLUSH: IDLE->RUN when en_i=1; RUN->IDLE when en_i=0; RUN->FLUSH on an accepted load whose clamped order differs from order_reg; FLUSH->RUN after exactly 1 cycle (FLUSH->IDLE if en_i=0).
REQ-017 SHALL, in IDLE and FLUSH, clear all accumulators, cancellation delay registers and y_o to 0; the LFSR SHALL keep running only in RUN.
REQ-018 SHALL, in RUN, update stage k (k<=order_reg): sum_k = acc_k + in_k as WIDTH+1 bits, carry c_k = sum_k[WIDTH], acc_k <= sum_k[WIDTH-1:0].
REQ-019 SHALL use in_1 = x_reg + (dither_reg ? lfsr[0] : 0) and in_k = sum_(k-1)[WIDTH-1:0] (combinational, same cycle) for k>1; stages above order_reg SHALL hold 0.
REQ-020 SHALL combine carries: d_m = c_m for m=order_reg; d_k = c_k + d_(k+1) - d_(k+1) delayed one cycle, for k<m; y_o <= d_1 registered (1-cycle latency from carry to output).
REQ-021 SHALL keep all d_k signed with range -(2^(m-1)-1)..2^(m-1); y_o (5 bits) SHALL never overflow for m<=4.
REQ-022 SHALL drive e_o = acc_m of the last active stage (registered).
REQ-023 SHALL step LFSR x^15+x^14+1 (Fibonacci, shift toward MSB, feedback into bit 0) once per RUN cycle.
REQ-024 SHALL, on a load accepted in RUN with unchanged order, apply new x/dither from the next cycle without clearing any state.
REQ-025 SHALL, when load_valid_i and en_i falling coincide, accept the load and enter IDLE.
REQ-026 SHALL produce long-run mean of y_o equal to x_reg/2^WIDTH (dither off) in every order.

Reset
REQ-027 SHALL on rst=1 set FSM=IDLE, x_reg=0, order_reg=1, dither_reg=0, lfsr=LFSR_SEED, all accumulators, delays, y_o, e_o = 0, busy_o=0, load_ready_o=1.
REQ-028 SHALL give rst priority over en_i and load_valid_i, including mid-RUN and mid-FLUSH.

Verification (WIDTH=8, MAX_ORDER=4)
REQ-029 SHALL test order 1, x=64, dither off, en_i high: y_o = 0,0,0,1 repeating, first 1 on the 5th cycle after RUN entry; e_o cycles 64,128,192,0.
REQ-030 SHALL test x=0, order 4, dither off: y_o=0 and e_o=0 for 1000 cycles.
REQ-031 SHALL test order 3, x=128, 2048 cycles: y_o within -3..4 always, sum of y_o = 1024 +/- 4.
REQ-032 SHALL test a load changing order 2->4 in RUN: load_ready_o low for 1 cycle, busy_o high, y_o=0 and e_o=0 that cycle, then restart from cleared state.
REQ-033 SHALL test rst pulse mid-RUN with dither on: next cycle all outputs 0, state IDLE, lfsr=LFSR_SEED, order_reg=1.
REQ-034 SHALL test x=255, order 4, dither on, 4096 cycles: y_o within -7..8, no accumulator overflow beyond carry, mean of y_o within 0.99..1.0.
